// File: rtl/prbs_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions used by the generator and checker.
`default_nettype none

package prbs_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_A  = 31;
  localparam int TAP_B  = 28;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } prbs_state_t;

  // Next bit of the sequence, predicted from the last 31 bits (MSB is oldest).
  function automatic logic prbs31_bit(input logic [LFSR_W-1:0] s);
    return s[TAP_A-1] ^ s[TAP_B-1];
  endfunction

  function automatic logic [LFSR_W-1:0] prbs31_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], prbs31_bit(s)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
`default_nettype none

module prbs_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prbs31_checker.sv
// Serial PRBS31 receive checker: self-seeds from the stream, verifies, then
// counts bit errors against the free-running local prediction.
`default_nettype none

module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int VERIFY_LEN  = 64,
  parameter int WIN_LEN     = 256,
  parameter int LOSS_THRESH = 16,
  parameter bit INVERT      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int ACQ_W = 5;
  localparam int VER_W = $clog2(VERIFY_LEN + 1);
  localparam int WIN_W = $clog2(WIN_LEN + 1);
  localparam int ERR_W = $clog2(LOSS_THRESH + 1);

  prbs_state_t        state, state_nx;
  logic [LFSR_W-1:0]  lfsr, lfsr_nx;
  logic [ACQ_W-1:0]   acq_cnt, acq_nx;
  logic [VER_W-1:0]   ver_cnt, ver_nx;
  logic [WIN_W-1:0]   win_cnt, win_nx;
  logic [ERR_W-1:0]   win_err, win_err_nx;
  logic               locked_nx, pulse_nx, loss_nx;
  logic               bit_inc, err_inc;

  logic               b, p, miss;
  logic [LFSR_W-1:0]  loaded;

  assign b      = din ^ INVERT;
  assign p      = prbs31_bit(lfsr);
  assign miss   = b ^ p;
  assign loaded = {lfsr[LFSR_W-2:0], b};

  always_comb begin
    state_nx   = state;
    lfsr_nx    = lfsr;
    acq_nx     = acq_cnt;
    ver_nx     = ver_cnt;
    win_nx     = win_cnt;
    win_err_nx = win_err;
    locked_nx  = locked;
    pulse_nx   = 1'b0;
    loss_nx    = 1'b0;
    bit_inc    = 1'b0;
    err_inc    = 1'b0;

    if (din_valid) begin
      case (state)
        ACQUIRE: begin
          lfsr_nx = loaded;
          if (acq_cnt == ACQ_W'(LFSR_W - 1)) begin
            acq_nx = '0;
            // An all-zero seed would lock the LFSR forever; reload instead.
            if (loaded != '0) begin
              state_nx = VERIFY;
              ver_nx   = '0;
            end
          end else begin
            acq_nx = acq_cnt + 1'b1;
          end
        end

        VERIFY: begin
          lfsr_nx = prbs31_next(lfsr);
          if (miss) begin
            state_nx = ACQUIRE;
            acq_nx   = '0;
            ver_nx   = '0;
          end else if (ver_cnt == VER_W'(VERIFY_LEN - 1)) begin
            state_nx   = LOCKED;
            ver_nx     = '0;
            win_nx     = '0;
            win_err_nx = '0;
            locked_nx  = 1'b1;
          end else begin
            ver_nx = ver_cnt + 1'b1;
          end
        end

        LOCKED: begin
          lfsr_nx  = prbs31_next(lfsr);
          bit_inc  = 1'b1;
          err_inc  = miss;
          pulse_nx = miss & ~clr;
          // Threshold test precedes the window rollover so a hit on the last bit still counts.
          if (miss && (win_err == ERR_W'(LOSS_THRESH - 1))) begin
            state_nx  = ACQUIRE;
            acq_nx    = '0;
            loss_nx   = 1'b1;
            locked_nx = 1'b0;
          end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
            win_nx     = '0;
            win_err_nx = '0;
          end else begin
            win_nx     = win_cnt + 1'b1;
            win_err_nx = win_err + ERR_W'(miss);
          end
        end

        default: begin
          state_nx = ACQUIRE;
          acq_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACQUIRE;
      lfsr      <= '0;
      acq_cnt   <= '0;
      ver_cnt   <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      state     <= state_nx;
      lfsr      <= lfsr_nx;
      acq_cnt   <= acq_nx;
      ver_cnt   <= ver_nx;
      win_cnt   <= win_nx;
      win_err   <= win_err_nx;
      locked    <= locked_nx;
      err_pulse <= pulse_nx;
      sync_loss <= loss_nx;
    end
  end

  prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (clr),
    .count (err_count)
  );

  prbs_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bit_inc),
    .clr   (clr),
    .count (bit_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_prbs31_checker.sv
// Scoreboarded bench for prbs31_checker: a 16-bit, a 4-bit and an inverted-stream instance.
`default_nettype none

module tb_prbs31_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clr = 1'b0;
  logic din_inv;
  assign din_inv = ~din;

  logic        locked_a, pulse_a, loss_a;
  logic [15:0] ec_a, bc_a;
  logic        locked_s, pulse_s, loss_s;
  logic [3:0]  ec_s, bc_s;
  logic        locked_i, pulse_i, loss_i;
  logic [15:0] ec_i, bc_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {check, err_pulse, sync_loss} per valid bit driven.
  logic [2:0] sb[$];
  logic [2:0] mon_e;
  logic [30:0] g;

  always #5 clk = ~clk;

  prbs31_checker #(.CNT_W(16), .INVERT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
    .locked(locked_a), .err_pulse(pulse_a), .sync_loss(loss_a),
    .err_count(ec_a), .bit_count(bc_a));

  prbs31_checker #(.CNT_W(4), .INVERT(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
    .locked(locked_s), .err_pulse(pulse_s), .sync_loss(loss_s),
    .err_count(ec_s), .bit_count(bc_s));

  prbs31_checker #(.CNT_W(16), .INVERT(1'b1)) dut_i (
    .clk(clk), .rst_n(rst_n), .din(din_inv), .din_valid(din_valid), .clr(clr),
    .locked(locked_i), .err_pulse(pulse_i), .sync_loss(loss_i),
    .err_count(ec_i), .bit_count(bc_i));

  // Scoreboard monitor: each consumed bit's expected pulses checked just after the edge.
  always @(posedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      #1;
      if (mon_e[2]) begin
        n_tests++;
        if ({pulse_a, pulse_s, pulse_i} !== {3{mon_e[1]}}) begin
          n_fail++;
          $display("FAIL err_pulse @%0t: got %b required %b", $time,
                   {pulse_a, pulse_s, pulse_i}, {3{mon_e[1]}});
        end
        n_tests++;
        if ({loss_a, loss_s, loss_i} !== {3{mon_e[0]}}) begin
          n_fail++;
          $display("FAIL sync_loss @%0t: got %b required %b", $time,
                   {loss_a, loss_s, loss_i}, {3{mon_e[0]}});
        end
      end
    end
  end

  task automatic reset_dut();
    rst_n = 1'b0; din_valid = 1'b1; din = 1'b1; clr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; din_valid = 1'b0;
    g = '1;
  endtask

  task automatic send_bit(input logic flip, input logic chk, input logic exp_pulse,
                          input logic exp_loss, input logic do_clr);
    logic o;
    o = g[30] ^ g[27];
    g = {g[29:0], o};
    din = o ^ flip; din_valid = 1'b1; clr = do_clr;
    sb.push_back({chk, exp_pulse, exp_loss});
    @(posedge clk); #1;
    din_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic send_clean(input int n);
    for (int k = 0; k < n; k++) send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_dut();
    n_tests++;
    if ({locked_a, pulse_a, loss_a, locked_s, locked_i} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {locked_a, pulse_a, loss_a, locked_s, locked_i});
    end
    n_tests++;
    if ({ec_a, bc_a, ec_s, bc_s, ec_i, bc_i} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got ec=%0d bc=%0d required 0", ec_a, bc_a);
    end
  endtask

  task automatic test_clean_lock();
    reset_dut();
    send_clean(94);
    n_tests++;
    if ({locked_a, locked_s, locked_i} !== 3'b000) begin
      n_fail++;
      $display("FAIL early_lock: got %b required 000", {locked_a, locked_s, locked_i});
    end
    send_clean(1);
    n_tests++;
    if ({locked_a, locked_s, locked_i} !== 3'b111) begin
      n_fail++;
      $display("FAIL lock_at_95: got %b required 111", {locked_a, locked_s, locked_i});
    end
    n_tests++;
    if (bc_a !== 16'd0) begin
      n_fail++;
      $display("FAIL bc_at_lock: got %0d required 0", bc_a);
    end
    send_clean(1000);
    n_tests++;
    if (bc_a !== 16'd1000 || bc_i !== 16'd1000 || bc_s !== 4'd15) begin
      n_fail++;
      $display("FAIL clean_bit_count: got %0d/%0d/%0d required 1000/15/1000", bc_a, bc_s, bc_i);
    end
    n_tests++;
    if (ec_a !== 16'd0 || ec_s !== 4'd0 || ec_i !== 16'd0) begin
      n_fail++;
      $display("FAIL clean_err_count: got %0d/%0d/%0d required 0", ec_a, ec_s, ec_i);
    end
  endtask

  task automatic test_injected_errors();
    reset_dut();
    send_clean(95);
    for (int idx = 95; idx < 600; idx++) begin
      if (idx == 200 || idx == 450) send_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      else send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (ec_a !== 16'd2 || ec_s !== 4'd2 || ec_i !== 16'd2) begin
      n_fail++;
      $display("FAIL inj_err_count: got %0d/%0d/%0d required 2", ec_a, ec_s, ec_i);
    end
    n_tests++;
    if (bc_a !== 16'd505) begin
      n_fail++;
      $display("FAIL inj_bit_count: got %0d required 505", bc_a);
    end
    n_tests++;
    if ({locked_a, locked_s, locked_i} !== 3'b111) begin
      n_fail++;
      $display("FAIL inj_locked: got %b required 111", {locked_a, locked_s, locked_i});
    end
  endtask

  task automatic test_loss_of_lock();
    reset_dut();
    send_clean(95);
    for (int k = 0; k < 16; k++) send_bit(1'b1, 1'b1, 1'b1, (k == 15), 1'b0);
    n_tests++;
    if ({locked_a, locked_s, locked_i} !== 3'b000) begin
      n_fail++;
      $display("FAIL loss_locked: got %b required 000", {locked_a, locked_s, locked_i});
    end
    n_tests++;
    if (ec_a !== 16'd16 || ec_s !== 4'd15 || ec_i !== 16'd16) begin
      n_fail++;
      $display("FAIL loss_err_count: got %0d/%0d/%0d required 16/15/16", ec_a, ec_s, ec_i);
    end
    send_clean(94);
    n_tests++;
    if ({locked_a, locked_i} !== 2'b00 || ec_a !== 16'd16) begin
      n_fail++;
      $display("FAIL relock_early: got locked=%b ec=%0d required 00 16", {locked_a, locked_i}, ec_a);
    end
    send_clean(1);
    n_tests++;
    if ({locked_a, locked_s, locked_i} !== 3'b111) begin
      n_fail++;
      $display("FAIL relock_95: got %b required 111", {locked_a, locked_s, locked_i});
    end
    // Threshold reached on the very last bit of a window.
    send_clean(240);
    for (int k = 0; k < 16; k++) send_bit(1'b1, 1'b1, 1'b1, (k == 15), 1'b0);
    n_tests++;
    if (locked_a !== 1'b0 || ec_a !== 16'd32 || bc_a !== 16'd272) begin
      n_fail++;
      $display("FAIL loss_last_bit: got locked=%b ec=%0d bc=%0d required 0 32 272", locked_a, ec_a, bc_a);
    end
  endtask

  task automatic test_acquire_edges();
    reset_dut();
    for (int k = 0; k < 31; k++) begin
      din = 1'b0; din_valid = 1'b1;
      sb.push_back(3'b100);
      @(posedge clk); #1;
      din_valid = 1'b0;
    end
    n_tests++;
    if ({locked_a, locked_i} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_seed_locked: got %b required 00", {locked_a, locked_i});
    end
    g = '1;
    send_clean(94);
    send_clean(1);
    n_tests++;
    if ({locked_a, locked_s, locked_i} !== 3'b111) begin
      n_fail++;
      $display("FAIL zero_seed_relock: got %b required 111", {locked_a, locked_s, locked_i});
    end
    reset_dut();
    send_clean(41);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (locked_a !== 1'b0 || ec_a !== 16'd0 || bc_a !== 16'd0) begin
      n_fail++;
      $display("FAIL verify_miss: got locked=%b ec=%0d bc=%0d required 0 0 0", locked_a, ec_a, bc_a);
    end
    send_clean(94);
    n_tests++;
    if (locked_a !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_reacq_early: got %b required 0", locked_a);
    end
    send_clean(1);
    n_tests++;
    if (locked_a !== 1'b1 || ec_a !== 16'd0) begin
      n_fail++;
      $display("FAIL verify_reacq_lock: got locked=%b ec=%0d required 1 0", locked_a, ec_a);
    end
  endtask

  task automatic test_clr_sat_gaps();
    reset_dut();
    send_clean(95);
    for (int p = 0; p < 400; p++) begin
      if (p % 20 == 19) send_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      else send_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (ec_a !== 16'd20 || ec_s !== 4'd15 || bc_a !== 16'd400 || bc_s !== 4'd15) begin
      n_fail++;
      $display("FAIL saturation: got ec=%0d/%0d bc=%0d/%0d required 20/15 400/15", ec_a, ec_s, bc_a, bc_s);
    end
    for (int k = 0; k < 10; k++) begin
      din = 1'($urandom); din_valid = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({pulse_a, loss_a, pulse_s} !== 3'b000) begin
        n_fail++;
        $display("FAIL gap_pulses: got %b required 000", {pulse_a, loss_a, pulse_s});
      end
    end
    n_tests++;
    if (ec_a !== 16'd20 || bc_a !== 16'd400 || locked_a !== 1'b1 || locked_s !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_frozen: got ec=%0d bc=%0d locked=%b required 20 400 1", ec_a, bc_a, locked_a);
    end
    send_clean(10);
    n_tests++;
    if (ec_a !== 16'd20 || bc_a !== 16'd410) begin
      n_fail++;
      $display("FAIL after_gap: got ec=%0d bc=%0d required 20 410", ec_a, bc_a);
    end
    send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (ec_a !== 16'd0 || bc_a !== 16'd0 || ec_s !== 4'd0 || bc_s !== 4'd0 || locked_a !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_with_err: got ec=%0d bc=%0d locked=%b required 0 0 1", ec_a, bc_a, locked_a);
    end
    send_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (ec_a !== 16'd1 || bc_a !== 16'd1) begin
      n_fail++;
      $display("FAIL after_clr: got ec=%0d bc=%0d required 1 1", ec_a, bc_a);
    end
  endtask

  task automatic test_reset_while_locked();
    send_clean(5);
    send_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (locked_a !== 1'b1 || ec_a !== 16'd2 || bc_a !== 16'd7) begin
      n_fail++;
      $display("FAIL pre_reset: got locked=%b ec=%0d bc=%0d required 1 2 7", locked_a, ec_a, bc_a);
    end
    rst_n = 1'b0; din_valid = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({locked_a, pulse_a, loss_a, locked_s, locked_i, pulse_i} !== 6'b0 ||
        {ec_a, bc_a, ec_s, bc_s, ec_i, bc_i} !== '0) begin
      n_fail++;
      $display("FAIL reset_while_locked: got locked=%b pulse=%b ec=%0d bc=%0d required 0",
               locked_a, pulse_a, ec_a, bc_a);
    end
    rst_n = 1'b1; din_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_injected_errors();
    test_loss_of_lock();
    test_acquire_edges();
    test_clr_sat_gaps();
    test_reset_while_locked();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
